// File: rtl/weight_read_sequencer.sv
// -----------------------------------------------------------------------------
// weight_read_sequencer
//
// Read-side initiator for the weight buffer. A command gives a base row, a row
// count and a pass count. The block issues one buffer read per cycle while
// credit is available. It catches the fixed-latency read data in a small FIFO
// and presents that data as a valid/ready stream to the matrix-multiply array.
// The buffer cannot stall, so a read goes out only when a FIFO slot is already
// reserved for its data (inflight + fifo_count < FIFO_DEPTH).
//
// Optional feature: define WREAD_PERF_CNT_EN to build the credit-stall counter.
// When it is undefined, stall_cycles is tied to 0.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_base_addr        first row
//   cmd_len              rows per pass (0 = no-op)
//   cmd_repeat           extra passes (total passes = cmd_repeat + 1)
//   mm_read_addr_valid   read request to the weight buffer
//   mm_read_addr         row being read
//   mm_read_data_valid   returned row valid (READ_LATENCY after the request)
//   mm_read_data         returned row
//   out_valid/out_ready  output stream handshake
//   out_data             output row
//   out_last             last row of the last pass
//   done                 one-cycle pulse when the command has drained
//   err_unexpected       sticky: data returned with no read in flight
//   stall_cycles         ISSUE cycles lost to missing credit
// -----------------------------------------------------------------------------
module weight_read_sequencer #(
  parameter int BUFFER_ADDR_WIDTH = 13,
  parameter int BUFFER_DATA_WIDTH = 8192,
  parameter int READ_LATENCY      = 4,
  parameter int FIFO_DEPTH        = 8,
  parameter int LEN_WIDTH         = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  input  logic [7:0]                   cmd_repeat,
  output logic                         mm_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr,
  input  logic                         mm_read_data_valid,
  input  logic [BUFFER_DATA_WIDTH-1:0] mm_read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUFFER_DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         done,
  output logic                         err_unexpected,
  output logic [31:0]                  stall_cycles
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TOT_W = LEN_WIDTH + 8;
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_nxt;

  // Command registers (data-like, loaded on accept)
  logic [BUFFER_ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [7:0]                   rep_q;
  logic [TOT_W-1:0]             total_q;

  // Control state
  logic [LEN_WIDTH-1:0]         row_idx;
  logic [7:0]                   pass_idx;
  logic [TOT_W-1:0]             popped_cnt;
  logic [CNT_W-1:0]             inflight;
  logic [CNT_W-1:0]             fifo_count;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic                         done_q;
  logic                         err_q;

  logic [BUFFER_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [CNT_W:0] credit_sum;
  logic           credit_ok;
  logic           accept;
  logic           issue;
  logic           last_issue;
  logic           ret;
  logic           push;
  logic           pop;
  logic           done_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit uses registered counts only, so a slot freed by a pop this cycle
  // becomes usable on the following cycle.
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < DEPTH_SUM;
  assign last_issue = (row_idx == len_q - LEN_WIDTH'(1)) && (pass_idx == rep_q);

  // Data arriving with nothing in flight is stale (e.g. issued before a reset).
  assign ret  = mm_read_data_valid && (inflight != '0);
  assign push = ret;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    cmd_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            accept = 1'b1;
            if (cmd_len == '0) done_nxt  = 1'b1;
            else               state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          issue = credit_ok;
          if (credit_ok && last_issue) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (pop && out_last && inflight == '0 && fifo_count == CNT_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Issue stage: command capture and address generation
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= cmd_base_addr;
      len_q   <= cmd_len;
      rep_q   <= cmd_repeat;
      total_q <= TOT_W'(cmd_len) * TOT_W'(cmd_repeat) + TOT_W'(cmd_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx    <= '0;
      pass_idx   <= '0;
      popped_cnt <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (mm_read_data_valid && inflight == '0) err_q <= 1'b1;

      if (accept) begin
        row_idx  <= '0;
        pass_idx <= '0;
      end else if (issue) begin
        if (row_idx == len_q - LEN_WIDTH'(1)) begin
          row_idx  <= '0;
          pass_idx <= pass_idx + 8'd1;
        end else begin
          row_idx <= row_idx + LEN_WIDTH'(1);
        end
      end

      if (accept)   popped_cnt <= '0;
      else if (pop) popped_cnt <= popped_cnt + TOT_W'(1);

      case ({issue, ret})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: ;
      endcase

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      // Credit accounting guarantees a free slot for every returning row.
      assert (!(push && !pop && fifo_count == DEPTH_CNT));
    end
  end

  // Return stage: buffer data captured into the FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mm_read_data;
  end

  assign mm_read_addr_valid = issue;
  assign mm_read_addr       = issue ? base_q + BUFFER_ADDR_WIDTH'(row_idx) : '0;
  assign out_valid          = (fifo_count != '0);
  assign out_data           = out_valid ? mem[rd_ptr] : '0;
  assign out_last           = out_valid && (popped_cnt == total_q - TOT_W'(1));
  assign done               = done_q;
  assign err_unexpected     = err_q;

`ifdef WREAD_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state == ISSUE && !credit_ok && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_weight_read_sequencer.sv
module tb_weight_read_sequencer;

  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int LAT = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } row_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr;
  logic [12:0]   cmd_len;
  logic [7:0]    cmd_repeat;
  logic          mm_read_addr_valid;
  logic [AW-1:0] mm_read_addr;
  logic          mm_read_data_valid;
  logic [DW-1:0] mm_read_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;
  logic          err_unexpected;
  logic [31:0]   stall_cycles;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;

  logic [AW-1:0] exp_addr[$];
  row_t          exp_row[$];

  int issue_cnt, row_cnt, done_cnt, issued_tot, popped_tot, max_out;
  int first_issue_rel, first_ov_rel, last_rel, done_rel;
  bit done_flag;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {6'h2B, a, a};
  endfunction

  weight_read_sequencer #(
    .BUFFER_ADDR_WIDTH(AW),
    .BUFFER_DATA_WIDTH(DW),
    .READ_LATENCY(LAT),
    .FIFO_DEPTH(8),
    .LEN_WIDTH(13)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len(cmd_len),
    .cmd_repeat(cmd_repeat),
    .mm_read_addr_valid(mm_read_addr_valid),
    .mm_read_addr(mm_read_addr),
    .mm_read_data_valid(mm_read_data_valid),
    .mm_read_data(mm_read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .done(done),
    .err_unexpected(err_unexpected),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight buffer model: fixed latency, never reset, cannot stall.
  logic [LAT-1:0] pv = '0;
  logic [AW-1:0]  pa [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mm_read_addr_valid};
    pa[0] <= mm_read_addr;
    for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
  end
  assign mm_read_data_valid = pv[LAT-1];
  assign mm_read_data       = data_of(pa[LAT-1]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every read request and row handshake.
  always @(negedge clk) begin
    int rel;
    int outstanding;
    logic [AW-1:0] ea;
    row_t er;
    rel = cyc - t0 + 1;
    outstanding = issued_tot - popped_tot;
    if (outstanding > max_out) max_out = outstanding;
    if (mm_read_addr_valid) begin
      issue_cnt++;
      issued_tot++;
      if (first_issue_rel < 0) first_issue_rel = rel;
      check("issue_expected", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) begin
        ea = exp_addr.pop_front();
        check("rd_addr", mm_read_addr, ea);
      end
    end
    if (out_valid && first_ov_rel < 0) first_ov_rel = rel;
    if (out_valid && out_last) last_rel = rel;
    if (out_valid && out_ready) begin
      row_cnt++;
      popped_tot++;
      check("row_expected", exp_row.size() != 0, 1);
      if (exp_row.size() != 0) begin
        er = exp_row.pop_front();
        check("row_data", out_data, er.data);
        check("row_last", out_last, er.last);
      end
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
      done_flag = 1'b1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_addr.delete();
    exp_row.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    issued_tot = 0;
    popped_tot = 0;
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] b, input logic [12:0] l, input logic [7:0] r);
    logic [AW-1:0] a;
    check("cmd_ready_idle", cmd_ready, 1);
    for (int p = 0; p <= int'(r); p++) begin
      for (int i = 0; i < int'(l); i++) begin
        a = b + AW'(i);
        exp_addr.push_back(a);
        exp_row.push_back('{data: data_of(a), last: (p == int'(r) && i == int'(l) - 1)});
      end
    end
    issue_cnt = 0; row_cnt = 0; done_cnt = 0; done_flag = 1'b0;
    first_issue_rel = -1; first_ov_rel = -1; last_rel = -1; done_rel = -1;
    cmd_base_addr = b; cmd_len = l; cmd_repeat = r; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_flag) break;
      @(posedge clk);
      #1;
    end
    check("done_seen", done_flag, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_base_addr = '0; cmd_len = '0;
    cmd_repeat = '0; out_ready = 1'b1;
    issue_cnt = 0; row_cnt = 0; done_cnt = 0; issued_tot = 0; popped_tot = 0;
    max_out = 0; done_flag = 1'b0;
    first_issue_rel = -1; first_ov_rel = -1; last_rel = -1; done_rel = -1;

    // Reset values
    do_reset();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_addr_valid", mm_read_addr_valid, 0);
    check("rst_addr", mm_read_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err_unexpected, 0);
    check("rst_stall", stall_cycles, 0);

    // Basic 4-row command, cycle-accurate timing
    send_cmd(13'h0010, 13'd4, 8'd0);
    wait_done(100);
    check("t1_first_issue_cycle", first_issue_rel, 1);
    check("t1_first_out_valid_cycle", first_ov_rel, 6);
    check("t1_last_cycle", last_rel, 9);
    check("t1_done_cycle", done_rel, 10);
    check("t1_issue_cnt", issue_cnt, 4);
    check("t1_row_cnt", row_cnt, 4);
    check("t1_cmd_ready_after", cmd_ready, 1);

    // Address wrap past the top row, two passes
    send_cmd(13'h1FFE, 13'd4, 8'd1);
    wait_done(200);
    check("t2_issue_cnt", issue_cnt, 8);
    check("t2_row_cnt", row_cnt, 8);
    check("t2_sb_empty", exp_row.size(), 0);
    check("t2_done_cnt", done_cnt, 1);

    // Backpressure: credit limits issue to FIFO_DEPTH reads
    out_ready = 1'b0;
    send_cmd(13'h0200, 13'd64, 8'd0);
    repeat (20) @(posedge clk);
    #1;
    check("t3_issue_stalled", issue_cnt, 8);
    check("t3_out_valid", out_valid, 1);
    check("t3_hold_data", out_data, data_of(13'h0200));
`ifdef WREAD_PERF_CNT_EN
    check("t3_stall_cnt", stall_cycles != 0, 1);
`else
    check("t3_stall_cnt", stall_cycles != 0, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("t3_hold_data_later", out_data, data_of(13'h0200));
    check("t3_still_stalled", issue_cnt, 8);
    out_ready = 1'b1;
    wait_done(400);
    check("t3_row_cnt", row_cnt, 64);
    check("t3_sb_empty", exp_row.size(), 0);
    check("t3_done_cnt", done_cnt, 1);

    // Zero-length command
    send_cmd(13'h0055, 13'd0, 8'd0);
    check("t4_cmd_ready_stays", cmd_ready, 1);
    wait_done(20);
    repeat (5) @(posedge clk);
    #1;
    check("t4_done_cycle", done_rel, 1);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_no_issue", issue_cnt, 0);

    // Reset with three reads in flight
    send_cmd(13'h0300, 13'd64, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_addr.delete();
    exp_row.delete();
    @(posedge clk);
    #1;
    check("t5_inflight_at_rst", issue_cnt, 3);
    rst = 1'b0;
    issued_tot = 0; popped_tot = 0; row_cnt = 0;
    #1;
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_addr_valid", mm_read_addr_valid, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_done", done, 0);
    check("t5_err_clear", err_unexpected, 0);
    check("t5_stall_clear", stall_cycles, 0);
    repeat (6) @(posedge clk);
    #1;
    check("t5_err_set", err_unexpected, 1);
    check("t5_no_rows", row_cnt, 0);
    check("t5_out_valid_after", out_valid, 0);

    // Random backpressure, 3 passes of 100 rows
    do_reset();
    check("t6_err_cleared", err_unexpected, 0);
    max_out = 0;
    send_cmd(13'h0100, 13'd100, 8'd2);
    for (int i = 0; i < 4000; i++) begin
      if (done_flag) break;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check("done_seen", done_flag, 1);
    check("t6_row_cnt", row_cnt, 300);
    check("t6_issue_cnt", issue_cnt, 300);
    check("t6_sb_empty", exp_row.size(), 0);
    check("t6_outstanding_le_depth", max_out <= 8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
